// File: rtl/nonce_sched_pkg.sv
// rtl/nonce_sched_pkg.sv - shared widths, FSM states and nonce byte-swap for nonce_scheduler
package nonce_sched_pkg;

  localparam int HEADER_W  = 640;
  localparam int DIGEST_W  = 256;
  localparam int NONCE_W   = 32;
  localparam int NONCE_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DRAIN,
    S_DONE
  } state_e;

  // The header carries the nonce little-endian, so the counter value is byte-reversed on insertion.
  function automatic logic [NONCE_W-1:0] nonce_bswap(input logic [NONCE_W-1:0] n);
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
  endfunction

endpackage

// File: rtl/target_compare.sv
// rtl/target_compare.sv - wide unsigned digest <= target comparator
module target_compare
  import nonce_sched_pkg::*;
(
  input  logic [DIGEST_W-1:0] i_digest,
  input  logic [DIGEST_W-1:0] i_target,
  output logic                o_hit
);

  assign o_hit = (i_digest <= i_target);

endmodule

// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - nonce sweep sequencer around one double-SHA-256 header core
module nonce_scheduler
  import nonce_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_job_valid,
  output logic                o_job_ready,
  input  logic [HEADER_W-1:0] i_job_header,
  input  logic [DIGEST_W-1:0] i_job_target,
  input  logic [NONCE_W-1:0]  i_job_nonce_start,
  input  logic [NONCE_W-1:0]  i_job_nonce_end,
  input  logic                i_abort,
  output logic                o_core_start,
  output logic [HEADER_W-1:0] o_core_header,
  input  logic                i_core_done,
  input  logic [DIGEST_W-1:0] i_core_digest,
  output logic                o_result_valid,
  output logic                o_result_found,
  output logic                o_result_aborted,
  output logic                o_result_error,
  output logic [NONCE_W-1:0]  o_result_nonce,
  output logic [DIGEST_W-1:0] o_result_digest,
  output logic [31:0]         o_hash_count
);

  localparam int TMPL_LSB = NONCE_LSB + NONCE_W;
  localparam int TMPL_W   = HEADER_W - TMPL_LSB;

  state_e               r_state;
  state_e               w_next_state;
  logic [TMPL_W-1:0]    r_template;
  logic [DIGEST_W-1:0]  r_target;
  logic [DIGEST_W-1:0]  r_digest;
  logic [NONCE_W-1:0]   r_nonce;
  logic [NONCE_W-1:0]   r_nonce_end;
  logic [31:0]          r_wdog;
  logic [HEADER_W-1:0]  r_core_header;
  logic                 r_result_valid;
  logic                 r_result_found;
  logic                 r_result_aborted;
  logic                 r_result_error;
  logic [NONCE_W-1:0]   r_result_nonce;
  logic [DIGEST_W-1:0]  r_result_digest;
  logic [31:0]          r_hash_count;

  logic                 w_hit;
  logic                 w_timeout;
  logic [NONCE_W-1:0]   w_nonce_inc;
  logic                 w_fin_found;
  logic                 w_fin_aborted;
  logic                 w_fin_error;
  logic [DIGEST_W-1:0]  w_fin_digest;
  logic                 w_unused_nonce_field;

  assign w_unused_nonce_field = ^i_job_header[TMPL_LSB-1:0];
  assign w_nonce_inc = r_nonce + 32'd1;
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_wdog == 32'(TIMEOUT_CYCLES - 1));

  target_compare u_target_compare (
    .i_digest (r_digest),
    .i_target (r_target),
    .o_hit    (w_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_fin_found   = 1'b0;
    w_fin_aborted = 1'b0;
    w_fin_error   = 1'b0;
    w_fin_digest  = '0;
    case (r_state)
      S_IDLE: if (i_job_valid) w_next_state = S_ISSUE;
      S_ISSUE: begin
        if (i_abort) begin
          w_next_state  = S_DONE;
          w_fin_aborted = 1'b1;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // A completion arriving with the abort leaves nothing to drain.
        if (i_abort) begin
          w_next_state  = i_core_done ? S_DONE : S_DRAIN;
          w_fin_aborted = i_core_done;
        end else if (i_core_done) begin
          w_next_state = S_CHECK;
        end else if (w_timeout) begin
          w_next_state = S_DONE;
          w_fin_error  = 1'b1;
        end
      end
      S_CHECK: begin
        w_fin_digest = r_digest;
        if (i_abort) begin
          w_next_state  = S_DONE;
          w_fin_aborted = 1'b1;
        end else if (w_hit) begin
          w_next_state = S_DONE;
          w_fin_found  = 1'b1;
        end else if (r_nonce == r_nonce_end) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (i_core_done || w_timeout) begin
          w_next_state  = S_DONE;
          w_fin_aborted = 1'b1;
          w_fin_error   = !i_core_done;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_template       <= '0;
      r_target         <= '0;
      r_digest         <= '0;
      r_nonce          <= '0;
      r_nonce_end      <= '0;
      r_wdog           <= '0;
      r_core_header    <= '0;
      r_result_valid   <= 1'b0;
      r_result_found   <= 1'b0;
      r_result_aborted <= 1'b0;
      r_result_error   <= 1'b0;
      r_result_nonce   <= '0;
      r_result_digest  <= '0;
      r_hash_count     <= '0;
    end else begin
      if (r_state == S_IDLE && i_job_valid) begin
        r_template       <= i_job_header[HEADER_W-1:TMPL_LSB];
        r_target         <= i_job_target;
        r_nonce          <= i_job_nonce_start;
        r_nonce_end      <= i_job_nonce_end;
        r_core_header    <= {i_job_header[HEADER_W-1:TMPL_LSB], nonce_bswap(i_job_nonce_start)};
        r_hash_count     <= '0;
        r_result_valid   <= 1'b0;
        r_result_found   <= 1'b0;
        r_result_aborted <= 1'b0;
        r_result_error   <= 1'b0;
      end
      if (r_state == S_CHECK && w_next_state == S_ISSUE) begin
        r_nonce       <= w_nonce_inc;
        r_core_header <= {r_template, nonce_bswap(w_nonce_inc)};
      end
      if (r_state == S_ISSUE) begin
        r_wdog <= '0;
      end else if (r_state == S_WAIT || r_state == S_DRAIN) begin
        r_wdog <= r_wdog + 32'd1;
      end
      if (r_state == S_WAIT && i_core_done && !i_abort) begin
        r_digest <= i_core_digest;
        if (r_hash_count != '1) r_hash_count <= r_hash_count + 32'd1;
      end
      if (r_state != S_DONE && w_next_state == S_DONE) begin
        r_result_valid   <= 1'b1;
        r_result_found   <= w_fin_found;
        r_result_aborted <= w_fin_aborted;
        r_result_error   <= w_fin_error;
        r_result_nonce   <= r_nonce;
        r_result_digest  <= w_fin_digest;
      end
    end
  end

  // An abort landing on the issue cycle withholds the start so no orphan completion follows.
  assign o_core_start     = (r_state == S_ISSUE) && !i_abort;
  assign o_job_ready      = (r_state == S_IDLE);
  assign o_core_header    = r_core_header;
  assign o_result_valid   = r_result_valid;
  assign o_result_found   = r_result_found;
  assign o_result_aborted = r_result_aborted;
  assign o_result_error   = r_result_error;
  assign o_result_nonce   = r_result_nonce;
  assign o_result_digest  = r_result_digest;
  assign o_hash_count     = r_hash_count;

endmodule

// File: tb/tb_nonce_scheduler.sv
// tb/tb_nonce_scheduler.sv - self-checking bench for nonce_scheduler
module tb_nonce_scheduler;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         job_valid;
  logic         job_ready;
  logic [639:0] job_header;
  logic [255:0] job_target;
  logic [31:0]  job_nonce_start;
  logic [31:0]  job_nonce_end;
  logic         abort;
  logic         core_start;
  logic [639:0] core_header;
  logic         core_done;
  logic [255:0] core_digest;
  logic         result_valid;
  logic         result_found;
  logic         result_aborted;
  logic         result_error;
  logic [31:0]  result_nonce;
  logic [255:0] result_digest;
  logic [31:0]  hash_count;

  always #5 clk = ~clk;

  nonce_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_job_valid       (job_valid),
    .o_job_ready       (job_ready),
    .i_job_header      (job_header),
    .i_job_target      (job_target),
    .i_job_nonce_start (job_nonce_start),
    .i_job_nonce_end   (job_nonce_end),
    .i_abort           (abort),
    .o_core_start      (core_start),
    .o_core_header     (core_header),
    .i_core_done       (core_done),
    .i_core_digest     (core_digest),
    .o_result_valid    (result_valid),
    .o_result_found    (result_found),
    .o_result_aborted  (result_aborted),
    .o_result_error    (result_error),
    .o_result_nonce    (result_nonce),
    .o_result_digest   (result_digest),
    .o_hash_count      (hash_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Model of the job outcome and of the nonce order the core must see
  logic [31:0]  exp_q[$];
  logic [639:0] exp_hdr;
  logic         exp_found, exp_aborted, exp_error, exp_dig_chk;
  logic [31:0]  exp_nonce, exp_count;
  logic [255:0] exp_digest;

  // Core behaviour: fixed latency, digest chosen per nonce
  int           core_lat;
  logic         core_mute;
  logic         hit_en;
  logic [31:0]  hit_n;
  logic [255:0] hit_dig, miss_dig;

  logic         chk_en = 1'b0;
  logic         result_seen = 1'b0;
  logic         prev_rv = 1'b0;
  int           n_starts = 0;
  int           first_start_cyc = 0, last_start_cyc = 0, rise_cyc = 0;
  int           accept_cyc = 0, done_cyc = 0, abort_cyc = 0;
  logic [31:0]  cmp_n, cmp_sw;

  function automatic logic [255:0] digest_of(input logic [31:0] n);
    return (hit_en && n == hit_n) ? hit_dig : miss_dig;
  endfunction

  initial begin
    int          pend;
    logic [31:0] pn;
    pend = 0;
    pn = '0;
    core_done = 1'b0;
    core_digest = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done = 1'b1;
          core_digest = digest_of(pn);
          done_cyc = cyc;
        end
      end
      if (core_start && !core_mute) begin
        pend = core_lat;
        pn = {<<8{core_header[31:0]}};
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (core_start) begin
        n_starts++;
        if (n_starts == 1) first_start_cyc = cyc;
        last_start_cyc = cyc;
        chk1("core_start_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cmp_n  = exp_q.pop_front();
          cmp_sw = {<<8{cmp_n}};
          chk("core_header", core_header, {exp_hdr[639:32], cmp_sw});
        end
      end
      if (result_valid && !prev_rv) begin
        result_seen = 1'b1;
        rise_cyc = cyc;
        chk1("result_found", result_found, exp_found);
        chk1("result_aborted", result_aborted, exp_aborted);
        chk1("result_error", result_error, exp_error);
        chk32("result_nonce", result_nonce, exp_nonce);
        chk32("hash_count", hash_count, exp_count);
        chk1("job_ready_in_done", job_ready, 1'b0);
        if (exp_dig_chk) chk("result_digest", result_digest, exp_digest);
      end
    end
    prev_rv = result_valid;
  end

  task automatic start_job(input logic [639:0] hdr, input logic [255:0] tgt,
                           input logic [31:0] s, input logic [31:0] e);
    logic [31:0]  n;
    logic [255:0] d;
    exp_q.delete();
    exp_hdr = hdr;
    exp_found = 1'b0;
    exp_aborted = 1'b0;
    exp_error = 1'b0;
    exp_dig_chk = 1'b0;
    exp_digest = '0;
    exp_nonce = '0;
    exp_count = '0;
    n = s;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(n);
      exp_count = exp_count + 32'd1;
      d = digest_of(n);
      if (d <= tgt) begin
        exp_found = 1'b1;
        exp_nonce = n;
        exp_digest = d;
        exp_dig_chk = 1'b1;
        break;
      end
      if (n == e) begin
        exp_nonce = n;
        break;
      end
      n = n + 32'd1;
    end
    result_seen = 1'b0;
    n_starts = 0;
    @(negedge clk);
    chk1("job_ready_idle", job_ready, 1'b1);
    job_header = hdr;
    job_target = tgt;
    job_nonce_start = s;
    job_nonce_end = e;
    job_valid = 1'b1;
    accept_cyc = cyc;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int k;
    k = 0;
    while (!result_seen && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk1({name, "_result_seen"}, result_seen, 1'b1);
    chk32({name, "_all_issued"}, exp_q.size(), 0);
  endtask

  function automatic logic [639:0] mk_hdr(input logic [31:0] t);
    return {{18{32'h0102_0304}}, t, 32'hDEAD_BEEF};
  endfunction

  logic [255:0] tgt_eq;

  initial begin
    int k;
    rst_n = 1'b0;
    job_valid = 1'b0;
    job_header = '0;
    job_target = '0;
    job_nonce_start = '0;
    job_nonce_end = '0;
    abort = 1'b0;
    core_lat = 10;
    core_mute = 1'b0;
    hit_en = 1'b0;
    hit_n = '0;
    hit_dig = '0;
    miss_dig = '1;
    tgt_eq = 256'h00000000_01234567_89ABCDEF_00112233_44556677_8899AABB_CCDDEEFF_01020304;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_job_ready", job_ready, 1'b1);
    chk1("rst_core_start", core_start, 1'b0);
    chk("rst_core_header", core_header[255:0], '0);
    chk1("rst_result_valid", result_valid, 1'b0);
    chk1("rst_flags", result_found | result_aborted | result_error, 1'b0);
    chk32("rst_result_nonce", result_nonce, 32'h0);
    chk("rst_result_digest", result_digest, '0);
    chk32("rst_hash_count", hash_count, 32'h0);
    chk_en = 1'b1;

    // single nonce, all-ones target
    start_job(mk_hdr(32'h1), '1, 32'h2, 32'h2);
    wait_result("single");
    chk32("single_starts", n_starts, 1);
    chk32("single_nonce", result_nonce, 32'h2);
    chk32("single_count", hash_count, 32'h1);
    chk1("single_found", result_found, 1'b1);
    chk32("accept_to_start", first_start_cyc - accept_cyc, 1);
    chk32("done_to_result", rise_cyc - done_cyc, 2);
    @(negedge clk);
    chk1("idle_ready_after_done", job_ready, 1'b1);
    chk1("idle_result_held", result_valid, 1'b1);

    // miss sweep 0x10..0x13
    start_job(mk_hdr(32'h2), '0, 32'h10, 32'h13);
    wait_result("sweep");
    chk32("sweep_starts", n_starts, 4);
    chk32("sweep_nonce", result_nonce, 32'h13);
    chk32("sweep_count", hash_count, 32'h4);
    chk1("sweep_found", result_found, 1'b0);
    chk32("sweep_issue_spacing", last_start_cyc - first_start_cyc, 3 * (10 + 2));

    // wrap FFFFFFFE -> 1, hit on 0
    hit_en = 1'b1;
    hit_n = 32'h0;
    hit_dig = 256'h0FFF;
    start_job(mk_hdr(32'h3), 256'h1000, 32'hFFFF_FFFE, 32'h1);
    wait_result("wrap");
    chk32("wrap_starts", n_starts, 3);
    chk32("wrap_nonce", result_nonce, 32'h0);
    chk1("wrap_found", result_found, 1'b1);
    chk("wrap_digest", result_digest, 256'h0FFF);

    // digest equal to target hits, target+1 misses
    hit_n = 32'h5;
    hit_dig = tgt_eq;
    start_job(mk_hdr(32'h4), tgt_eq, 32'h5, 32'h5);
    wait_result("eq_hit");
    chk1("eq_hit_found", result_found, 1'b1);
    hit_dig = tgt_eq + 256'd1;
    start_job(mk_hdr(32'h5), tgt_eq, 32'h5, 32'h5);
    wait_result("eq_miss");
    chk1("eq_miss_found", result_found, 1'b0);
    chk32("eq_miss_count", hash_count, 32'h1);

    // abort during the second WAIT, completion 5 cycles later
    hit_en = 1'b0;
    start_job(mk_hdr(32'h6), '0, 32'h20, 32'h30);
    k = 0;
    while (n_starts < 2 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk32("abort_second_issue", n_starts, 2);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    abort_cyc = cyc;
    exp_q.delete();
    exp_count = 32'h1;
    exp_found = 1'b0;
    exp_aborted = 1'b1;
    exp_error = 1'b0;
    exp_nonce = 32'h21;
    exp_digest = '0;
    exp_dig_chk = 1'b1;
    wait_result("abort");
    abort = 1'b0;
    chk32("abort_drain_latency", rise_cyc - abort_cyc, 6);
    repeat (10) @(negedge clk);
    chk32("abort_no_more_starts", n_starts, 2);

    // watchdog: core never answers
    core_mute = 1'b1;
    start_job(mk_hdr(32'h7), '1, 32'h40, 32'h40);
    exp_count = 32'h0;
    exp_found = 1'b0;
    exp_error = 1'b1;
    exp_nonce = 32'h40;
    exp_digest = '0;
    exp_dig_chk = 1'b1;
    wait_result("watchdog");
    chk32("watchdog_latency", rise_cyc - first_start_cyc, TO + 1);

    // reset in the middle of WAIT
    start_job(mk_hdr(32'h8), '1, 32'h50, 32'h50);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("midrst_core_start", core_start, 1'b0);
    chk("midrst_core_header", core_header[255:0], '0);
    chk1("midrst_result_valid", result_valid, 1'b0);
    chk32("midrst_result_nonce", result_nonce, 32'h0);
    chk32("midrst_hash_count", hash_count, 32'h0);
    chk1("midrst_job_ready", job_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_job_ready", job_ready, 1'b1);
    chk1("post_rst_core_start", core_start, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

endmodule
